axis_i2c_slave: RTL and testbench

I2C target (responder) with a 7-bit address. It is the far-end counterpart of the AXI-Stream I2C master.
- Bytes written by the bus master leave on an AXI-Stream master port.
- Bytes read by the bus master are taken from an AXI-Stream slave port.
- Used as the bus-level model/peer for the master and as a standalone target block.
- SCL/SDA are oversampled on the system clock; no internal FIFO (single-byte holding registers).

---
 rtl/axis_i2c_slave.sv | 227 ++++++++++++++++++++++
 tb/tb_axis_i2c_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_slave.sv
// I2C target with a 7-bit address: bus writes leave on m_axis, bus reads are served from s_axis.
// Optional SCL clock stretching on a full holding register or an empty read source: AXIS_I2C_SLAVE_CLK_STRETCH_EN.
`timescale 1ns/1ps
module axis_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tuser,
  output logic       busy
);
`ifdef AXIS_I2C_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK, S_WR_DATA, S_WR_ACK,
    S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [NS-1:0] scl_sync_q, sda_sync_q;
  logic          scl_d1_q, sda_d1_q;
  logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [7:0] shreg_q;
  logic [2:0] cnt_q;
  logic       rw_q, first_q, ack_q, mack_q, pend_q;
  logic       sda_oe_q, scl_oe_q, s_tready_q, m_tvalid_q, m_tuser_q, busy_q;
  logic [7:0] m_tdata_q;
  logic [7:0] shift_d, rd_byte_d;
  logic       wr_free, rd_load_ok, do_rd_load;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[NS-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[NS-2:0], sda_i};
      scl_d1_q   <= scl_sync_q[NS-1];
      sda_d1_q   <= sda_sync_q[NS-1];
    end
  end

  assign scl_s     = scl_sync_q[NS-1];
  assign sda_s     = sda_sync_q[NS-1];
  assign scl_rise  = scl_s & ~scl_d1_q;
  assign scl_fall  = ~scl_s & scl_d1_q;
  assign start_det = scl_s & scl_d1_q & sda_d1_q & ~sda_s;
  assign stop_det  = scl_s & scl_d1_q & ~sda_d1_q & sda_s;

  assign shift_d    = {shreg_q[6:0], sda_s};
  assign wr_free    = ~m_tvalid_q | m_axis_tready;
  assign rd_byte_d  = s_axis_tvalid ? s_axis_tdata : 8'hFF;
  assign rd_load_ok = s_axis_tvalid | ~STRETCH;
  // Read bytes are loaded on the ACK falling edge so bit 7 appears on that same low phase.
  assign do_rd_load = (state_q == S_RD_LOAD) ||
                      (scl_fall && state_q == S_ACK && rw_q) ||
                      (scl_fall && state_q == S_RD_ACK && mack_q);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'h00;
      cnt_q      <= 3'd0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ack_q      <= 1'b0;
      mack_q     <= 1'b0;
      pend_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      s_tready_q <= 1'b0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s_tready_q <= 1'b0;
      scl_oe_q   <= 1'b0;
      if (m_tvalid_q && m_axis_tready) m_tvalid_q <= 1'b0;
      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= 3'd0;
        ack_q    <= 1'b0;
        pend_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        pend_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_WAIT_STOP, S_RD_LOAD: ;
          S_ADDR: begin
            if (scl_rise) begin
              shreg_q <= shift_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) ack_q <= 1'b1;
            end else if (scl_fall && ack_q) begin
              if (shreg_q[7:1] == SLAVE_ADDR) begin
                sda_oe_q <= 1'b1;
                rw_q     <= shreg_q[0];
                first_q  <= ~shreg_q[0];
                state_q  <= S_ACK;
              end else begin
                state_q  <= S_WAIT_STOP;
              end
            end
          end
          S_ACK: begin
            if (scl_fall && !rw_q) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 3'd0;
              state_q  <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              shreg_q <= shift_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_q <= S_WR_ACK;
                if (wr_free) begin
                  m_tdata_q  <= shift_d;
                  m_tvalid_q <= 1'b1;
                  m_tuser_q  <= first_q;
                  first_q    <= 1'b0;
                  ack_q      <= 1'b1;
                end else begin
                  ack_q  <= 1'b0;
                  pend_q <= STRETCH;
                end
              end
            end
          end
          S_WR_ACK: begin
            if (pend_q && wr_free) begin
              m_tdata_q  <= shreg_q;
              m_tvalid_q <= 1'b1;
              m_tuser_q  <= first_q;
              first_q    <= 1'b0;
              pend_q     <= 1'b0;
              ack_q      <= 1'b1;
            end
            // While stretching, SCL is released one cycle after the ACK is on SDA.
            if (scl_oe_q) begin
              scl_oe_q <= 1'b1;
              if (!pend_q) begin
                sda_oe_q <= 1'b1;
                state_q  <= S_ACK;
              end
            end else if (scl_fall) begin
              if (pend_q) begin
                scl_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= ack_q;
                state_q  <= ack_q ? S_ACK : S_WAIT_STOP;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              if (cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                mack_q   <= 1'b0;
                state_q  <= S_RD_ACK;
              end else begin
                shreg_q  <= {shreg_q[6:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
                cnt_q    <= cnt_q + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) state_q <= S_WAIT_STOP;
              else       mack_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
        if (do_rd_load) begin
          if (rd_load_ok) begin
            shreg_q    <= rd_byte_d;
            sda_oe_q   <= ~rd_byte_d[7];
            s_tready_q <= s_axis_tvalid;
            cnt_q      <= 3'd0;
            scl_oe_q   <= scl_oe_q;
            state_q    <= S_RD_DATA;
          end else begin
            sda_oe_q <= 1'b0;
            scl_oe_q <= 1'b1;
            state_q  <= S_RD_LOAD;
          end
        end
      end
    end
  end

  assign sda_oe        = sda_oe_q;
  assign scl_oe        = scl_oe_q;
  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tuser  = m_tuser_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_axis_i2c_slave.sv
// Bit-banged I2C master driving axis_i2c_slave; m_axis bytes are checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_axis_i2c_slave;
  logic       clk = 1'b0;
  logic       arstn;
  logic       m_scl_low, m_sda_low;
  logic       scl_line, sda_line;
  logic       sda_oe, scl_oe;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready, m_tuser, busy;

  always #5 clk = ~clk;
  assign scl_line = ~(m_scl_low | scl_oe);
  assign sda_line = ~(m_sda_low | sda_oe);

  axis_i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .arstn(arstn), .scl_i(scl_line), .sda_i(sda_line),
    .sda_oe(sda_oe), .scl_oe(scl_oe),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tuser(m_tuser), .busy(busy)
  );

  typedef struct packed { logic [7:0] d; logic u; } mexp_t;
  mexp_t      exp_q[$];
  logic [7:0] rd_q[$];
  int         n_checks = 0, n_pass = 0, rd_pulses = 0;
  logic       saw_stretch = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic qwait;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic scl_high;
    int t;
    m_scl_low = 1'b0;
    t = 0;
    while (scl_line !== 1'b1 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 4000) begin
      n_checks++;
      $display("FAIL scl_release_timeout: SCL still low after %0d cycles, required released", t);
    end
    #1;
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0; qwait;
    scl_high;         qwait;
    m_sda_low = 1'b1; qwait;
    m_scl_low = 1'b1; qwait;
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; qwait;
    scl_high;         qwait;
    m_sda_low = 1'b0; qwait;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; qwait;
      scl_high;          qwait;
      m_scl_low = 1'b1;  qwait;
    end
    m_sda_low = 1'b0; qwait;
    scl_high;         qwait;
    ack = sda_line;
    m_scl_low = 1'b1; qwait;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    m_sda_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      qwait;
      scl_high; qwait;
      b = {b[6:0], sda_line};
      m_scl_low = 1'b1; qwait;
    end
    m_sda_low = ~nack; qwait;
    scl_high;          qwait;
    m_scl_low = 1'b1;  qwait;
    m_sda_low = 1'b0;
  endtask

  // Scoreboard monitor: every m_axis handshake pops one expected byte.
  initial begin
    mexp_t e;
    forever begin
      @(negedge clk);
      if (scl_oe) saw_stretch = 1'b1;
      if (arstn && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL m_axis_unexpected: got byte %02h, required none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("m_axis_tdata", {24'h0, m_tdata}, {24'h0, e.d});
          check("m_axis_tuser", {31'h0, m_tuser}, {31'h0, e.u});
        end
      end
    end
  end

  // Read-data source: presents rd_q head, pops on each tready pulse.
  initial begin
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        rd_pulses++;
        if (rd_q.size() > 0) void'(rd_q.pop_front());
      end
      s_tvalid = (rd_q.size() > 0);
      s_tdata  = (rd_q.size() > 0) ? rd_q[0] : 8'h00;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         p0;
    arstn = 1'b0; m_scl_low = 1'b0; m_sda_low = 1'b0; m_tready = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rst_sda_oe",   {31'h0, sda_oe},   0);
    check("rst_scl_oe",   {31'h0, scl_oe},   0);
    check("rst_s_tready", {31'h0, s_tready}, 0);
    check("rst_m_tvalid", {31'h0, m_tvalid}, 0);
    check("rst_m_tdata",  {24'h0, m_tdata},  0);
    check("rst_m_tuser",  {31'h0, m_tuser},  0);
    check("rst_busy",     {31'h0, busy},     0);
    arstn = 1'b1;
    repeat (10) @(posedge clk); #1;

    // Plain write of two bytes.
    i2c_start;
    check("busy_after_start", {31'h0, busy}, 1);
    write_byte(8'hA0, ack); check("wr_addr_ack", {31'h0, ack}, 0);
    exp_q.push_back('{d: 8'h12, u: 1'b1});
    write_byte(8'h12, ack); check("wr_12_ack", {31'h0, ack}, 0);
    exp_q.push_back('{d: 8'h34, u: 1'b0});
    write_byte(8'h34, ack); check("wr_34_ack", {31'h0, ack}, 0);
    i2c_stop;
    repeat (5) @(posedge clk); #1;
    check("busy_after_stop", {31'h0, busy}, 0);

    // Wrong address: no ACK, bus ignored until STOP.
    i2c_start;
    write_byte(8'hA2, ack); check("addr51_nack", {31'h0, ack}, 1);
    write_byte(8'h55, ack); check("ignored_byte_nack", {31'h0, ack}, 1);
    check("ignored_no_tvalid", {31'h0, m_tvalid}, 0);
    check("ignored_busy", {31'h0, busy}, 1);
    i2c_stop;

    // Read two bytes, ACK then NACK.
    rd_q.push_back(8'h5A); rd_q.push_back(8'hC3);
    repeat (3) @(posedge clk); #1;
    p0 = rd_pulses;
    i2c_start;
    write_byte(8'hA1, ack); check("rd_addr_ack", {31'h0, ack}, 0);
    read_byte(1'b0, rb); check("rd_byte_5a", {24'h0, rb}, 32'h5A);
    read_byte(1'b1, rb); check("rd_byte_c3", {24'h0, rb}, 32'hC3);
    check("rd_tready_pulses", rd_pulses - p0, 2);
    check("rd_wait_stop_busy", {31'h0, busy}, 1);
    i2c_stop;

    // Write three bytes into a blocked downstream.
    m_tready = 1'b0;
    i2c_start;
    write_byte(8'hA0, ack); check("full_addr_ack", {31'h0, ack}, 0);
`ifdef AXIS_I2C_SLAVE_CLK_STRETCH_EN
    exp_q.push_back('{d: 8'h01, u: 1'b1});
    exp_q.push_back('{d: 8'h02, u: 1'b0});
    exp_q.push_back('{d: 8'h03, u: 1'b0});
    fork begin repeat (1200) @(posedge clk); m_tready = 1'b1; end join_none
    write_byte(8'h01, ack); check("full_01_ack", {31'h0, ack}, 0);
    write_byte(8'h02, ack); check("full_02_ack", {31'h0, ack}, 0);
    write_byte(8'h03, ack); check("full_03_ack", {31'h0, ack}, 0);
    check("stretch_seen", {31'h0, saw_stretch}, 1);
`else
    exp_q.push_back('{d: 8'h01, u: 1'b1});
    write_byte(8'h01, ack); check("full_01_ack", {31'h0, ack}, 0);
    write_byte(8'h02, ack); check("full_02_nack", {31'h0, ack}, 1);
    write_byte(8'h03, ack); check("full_03_nack", {31'h0, ack}, 1);
`endif
    i2c_stop;
    m_tready = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Read with an empty source.
    p0 = rd_pulses;
    i2c_start;
    write_byte(8'hA1, ack); check("empty_addr_ack", {31'h0, ack}, 0);
`ifdef AXIS_I2C_SLAVE_CLK_STRETCH_EN
    fork begin repeat (600) @(posedge clk); rd_q.push_back(8'h77); end join_none
    read_byte(1'b1, rb); check("empty_stretch_byte", {24'h0, rb}, 32'h77);
    check("empty_stretch_pulses", rd_pulses - p0, 1);
`else
    read_byte(1'b1, rb); check("empty_byte_ff", {24'h0, rb}, 32'hFF);
    check("empty_no_pulse", rd_pulses - p0, 0);
`endif
    i2c_stop;

    // Repeated START from write into read.
    rd_q.push_back(8'h3C);
    i2c_start;
    write_byte(8'hA0, ack); check("rs_wr_addr_ack", {31'h0, ack}, 0);
    exp_q.push_back('{d: 8'h99, u: 1'b1});
    write_byte(8'h99, ack); check("rs_99_ack", {31'h0, ack}, 0);
    i2c_start;
    write_byte(8'hA1, ack); check("rs_rd_addr_ack", {31'h0, ack}, 0);
    read_byte(1'b1, rb); check("rs_byte_3c", {24'h0, rb}, 32'h3C);
    i2c_stop;

    // Reset while the target drives SDA low in a read.
    rd_q.push_back(8'h00);
    i2c_start;
    write_byte(8'hA1, ack); check("rst_rd_addr_ack", {31'h0, ack}, 0);
    check("rd_bit7_driven", {31'h0, sda_oe}, 1);
    repeat (2) begin qwait; scl_high; qwait; m_scl_low = 1'b1; end
    repeat (4) @(posedge clk); #1;
    check("rd_bit5_driven", {31'h0, sda_oe}, 1);
    arstn = 1'b0; #1;
    check("midrst_sda_oe", {31'h0, sda_oe}, 0);
    check("midrst_scl_oe", {31'h0, scl_oe}, 0);
    check("midrst_busy",   {31'h0, busy},   0);
    repeat (3) @(posedge clk); #1;
    arstn = 1'b1; m_scl_low = 1'b0; m_sda_low = 1'b0;
    repeat (20) @(posedge clk); #1;
    i2c_start;
    write_byte(8'hA0, ack); check("post_rst_addr_ack", {31'h0, ack}, 0);
    exp_q.push_back('{d: 8'h42, u: 1'b1});
    write_byte(8'h42, ack); check("post_rst_42_ack", {31'h0, ack}, 0);
    i2c_stop;
    repeat (10) @(posedge clk); #1;

    check("m_axis_all_drained", exp_q.size(), 0);
`ifndef AXIS_I2C_SLAVE_CLK_STRETCH_EN
    check("scl_never_stretched", {31'h0, saw_stretch}, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
